fifo_push_arbiter: RTL

//  Round-robin arbiter sharing the single push port of the FIFO (width=4, length=4) among NREQ producers.

---
 rtl/fifo_push_arbiter_if.sv | 14 +
 rtl/fifo_push_arbiter.sv | 65 ++++++
 2 files changed

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: producer/FIFO push-side bundle; master = producers+FIFO stub, slave = arbiter
interface fifo_push_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_push;
  logic [WIDTH-1:0]      fifo_data;
  logic                  fifo_full;
  modport master (output req, req_data, fifo_full, input gnt, fifo_push, fifo_data);
  modport slave  (input req, req_data, fifo_full, output gnt, fifo_push, fifo_data);
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst arbiter sharing one FIFO push port; ports clk, rst, bus (req/req_data/fifo_full in, gnt/fifo_push/fifo_data out), stat_cnt only with FIFO_ARB_STATS_EN
module fifo_push_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_push_arbiter_if.slave   bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   stat_cnt
`endif
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state;
  logic [PW-1:0] owner, sel, p, gnt_idx;
  logic [CW-1:0] burst_cnt;
  logic          found, burst_go, gnt_v;
  always_comb begin
    sel   = owner;
    found = 1'b0;
    p     = owner;
    for (int k = 0; k < NREQ; k++) begin
      p = p == PW'(NREQ - 1) ? '0 : p + 1'b1;
      if (!found && bus.req[p]) begin
        found = 1'b1;
        sel   = p;
      end
    end
    burst_go      = state == BURST && bus.req[owner];
    gnt_idx       = burst_go ? owner : sel;
    gnt_v         = !rst && !bus.fifo_full && (burst_go || found);
    bus.gnt       = gnt_v ? NREQ'(1) << gnt_idx : '0;
    bus.fifo_push = gnt_v;
    bus.fifo_data = gnt_v ? bus.req_data[gnt_idx*WIDTH +: WIDTH] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= PW'(NREQ - 1);
      burst_cnt <= '0;
    end else if (gnt_v && burst_go) begin
      burst_cnt <= burst_cnt + 1'b1;
      state     <= burst_cnt + 1'b1 == CW'(MAX_BURST) ? IDLE : BURST;
    end else if (gnt_v) begin
      owner     <= sel;
      burst_cnt <= CW'(1);
      state     <= MAX_BURST > 1 ? BURST : IDLE;
    end else if (state == BURST && !bus.fifo_full && !bus.req[owner]) begin
      // owner dropped with nobody else waiting: ownership is still released
      state <= IDLE;
    end
  end
`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (rst) stat_cnt[i*16 +: 16] <= '0;
      else if (bus.gnt[i] && bus.req[i] && stat_cnt[i*16 +: 16] != 16'hFFFF)
        stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
  end
`endif
endmodule
